// File: rtl/icache_pkg.sv
// Shared types and helpers for the instruction-cache refill controller.
// ICACHE_PREFETCH_EN adds the next-line prefetch states.
package icache_pkg;

  localparam int DEF_PC_W    = 32;
  localparam int DEF_WORD_W  = 32;
  localparam int DEF_BLOCK_W = 128;
  localparam int WPB         = DEF_BLOCK_W / DEF_WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_WRITE
`ifdef ICACHE_PREFETCH_EN
    , ST_PF_REQ,
    ST_PF_FILL
`endif
  } refill_state_t;

  // Clears the byte-offset bits of a line; callers truncate to their PC width.
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// Collects WPB RAM beats into one cache line; beat 0 lands in the MSBs.
module icache_line_assembler #(
  parameter int WORD_W = 32,
  parameter int WPB    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  beat_en_i,
  input  logic [WORD_W-1:0]     rdata_i,
  output logic [WORD_W*WPB-1:0] line_o,
  output logic                  last_o
);
  localparam int CNT_W = $clog2(WPB);

  logic [WORD_W-1:0] slot_q [WPB];
  logic [CNT_W-1:0]  beat_cnt_q;

  // The counter wraps to zero after the last beat, ready for the next burst.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
      for (int i = 0; i < WPB; i++) slot_q[i] <= '0;
    end else if (beat_en_i) begin
      slot_q[beat_cnt_q] <= rdata_i;
      beat_cnt_q         <= beat_cnt_q + 1'b1;
    end
  end

  assign last_o = beat_en_i && (beat_cnt_q == CNT_W'(WPB - 1));

  always_comb begin
    line_o = '0;
    for (int i = 0; i < WPB; i++) line_o[(WPB-1-i)*WORD_W +: WORD_W] = slot_q[i];
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss/refill controller: one burst per miss, line write, fetch stall.
// ICACHE_PREFETCH_EN adds a one-line next-line prefetch buffer.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int WORD_W  = DEF_WORD_W,
  parameter int BLOCK_W = DEF_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc,
  input  logic               cache_hit,
  input  logic               flush,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [WORD_W-1:0]  mem_rdata,
  output logic               cache_we,
  output logic [PC_W-1:0]    cache_waddr,
  output logic [BLOCK_W-1:0] cache_wdata,
  output logic               stall
);
  localparam int WPB_L = BLOCK_W / WORD_W;
  localparam int OFF_W = $clog2(BLOCK_W / 8);

  refill_state_t      state_q, state_d;
  logic [PC_W-1:0]    line_addr_q, line_addr_d, pc_line;
  logic               squash_q, squash_d;
  logic               fill_en, fill_last;
  logic [BLOCK_W-1:0] fill_line;

  assign pc_line = PC_W'(line_align(64'(pc), OFF_W));
  assign fill_en = (state_q == ST_FILL) && mem_rvalid;

  icache_line_assembler #(.WORD_W(WORD_W), .WPB(WPB_L)) u_fill (
    .clk_i(clk), .rst_i(rst), .beat_en_i(fill_en), .rdata_i(mem_rdata),
    .line_o(fill_line), .last_o(fill_last)
  );

`ifdef ICACHE_PREFETCH_EN
  localparam logic [PC_W-1:0] LINE_BYTES = PC_W'(BLOCK_W / 8);

  logic               pf_valid_q, pf_valid_d, from_pf_q, from_pf_d;
  logic               pf_en, pf_last, pf_hit;
  logic [PC_W-1:0]    pf_addr_q, pf_addr_d;
  logic [BLOCK_W-1:0] pf_data;

  assign pf_en  = (state_q == ST_PF_FILL) && mem_rvalid;
  assign pf_hit = pf_valid_q && (pc_line == pf_addr_q);

  icache_line_assembler #(.WORD_W(WORD_W), .WPB(WPB_L)) u_pf (
    .clk_i(clk), .rst_i(rst), .beat_en_i(pf_en), .rdata_i(mem_rdata),
    .line_o(pf_data), .last_o(pf_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_valid_q <= 1'b0;
      pf_addr_q  <= '0;
      from_pf_q  <= 1'b0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_addr_q  <= pf_addr_d;
      from_pf_q  <= from_pf_d;
    end
  end

  assign mem_req     = (state_q == ST_REQ) || (state_q == ST_PF_REQ);
  assign mem_addr    = (state_q == ST_PF_REQ) ? pf_addr_q : line_addr_q;
  assign cache_wdata = from_pf_q ? pf_data : fill_line;
  assign stall       = ~cache_hit | ((state_q != ST_IDLE) && (state_q != ST_PF_REQ) &&
                                     (state_q != ST_PF_FILL));
`else
  assign mem_req     = (state_q == ST_REQ);
  assign mem_addr    = line_addr_q;
  assign cache_wdata = fill_line;
  assign stall       = ~cache_hit | (state_q != ST_IDLE);
`endif

  assign cache_we    = (state_q == ST_WRITE);
  assign cache_waddr = line_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      line_addr_q <= '0;
      squash_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      squash_q    <= squash_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    squash_d    = squash_q;
`ifdef ICACHE_PREFETCH_EN
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    from_pf_d   = from_pf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!cache_hit && !flush) begin
          line_addr_d = pc_line;
`ifdef ICACHE_PREFETCH_EN
          if (pf_hit) begin
            state_d    = ST_WRITE;
            pf_valid_d = 1'b0;
            from_pf_d  = 1'b1;
          end else begin
            state_d    = ST_REQ;
            from_pf_d  = 1'b0;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
      // A flush that coincides with the grant cannot cancel the burst any more.
      ST_REQ: begin
        if (mem_gnt) begin
          state_d  = ST_FILL;
          squash_d = flush;
        end else if (flush) begin
          state_d  = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (flush) squash_d = 1'b1;
        if (fill_last) begin
          state_d  = (squash_q || flush) ? ST_IDLE : ST_WRITE;
          squash_d = 1'b0;
        end
      end
      ST_WRITE: begin
`ifdef ICACHE_PREFETCH_EN
        state_d    = ST_PF_REQ;
        pf_addr_d  = line_addr_q + LINE_BYTES;
        pf_valid_d = 1'b0;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef ICACHE_PREFETCH_EN
      ST_PF_REQ: begin
        if (mem_gnt) state_d = ST_PF_FILL;
      end
      ST_PF_FILL: begin
        if (pf_last) begin
          state_d    = ST_IDLE;
          pf_valid_d = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed and randomized refill scenarios against a transaction-level reference model.
module tb_icache_refill_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc;
  logic         cache_hit, flush;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt, mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         cache_we;
  logic [31:0]  cache_waddr;
  logic [127:0] cache_wdata;
  logic         stall;

  int checks = 0;
  int errors = 0;
  int pen;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .clk(clk), .rst(rst), .pc(pc), .cache_hit(cache_hit), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .cache_we(cache_we),
    .cache_waddr(cache_waddr), .cache_wdata(cache_wdata), .stall(stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One miss transaction. Expected line = beats concatenated in arrival order,
  // expected address = pc with the 16-byte offset cleared, stall drops two
  // cycles after the last beat.
  task automatic refill(input logic [31:0] p, input int gd, input int gmin, input int gmax,
                        input int flush_after, input bit flush_wr, input bit fixed,
                        output int penalty);
    logic [31:0]  beats [4];
    logic [127:0] line;
    logic [31:0]  la;
    int           cyc, lcyc, gap;
    bit           squashed;
    la   = p & ~32'hF;
    line = '0;
    for (int k = 0; k < 4; k++) begin
      beats[k] = fixed ? (32'hA + 32'(k)) : $urandom();
      line     = {line[95:0], beats[k]};
    end
    cyc = 0;
    squashed = 1'b0;
    pc = p; cache_hit = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #2;
    chk("miss_noreq", 128'(mem_req), 128'(0));
    chk("miss_stall", 128'(stall), 128'(1));
    tick(); cyc++;
    for (int d = 0; d <= gd; d++) begin
      mem_gnt = (d == gd);
      #2;
      chk("req", 128'(mem_req), 128'(1));
      chk("req_addr", 128'(mem_addr), 128'(la));
      tick(); cyc++;
    end
    mem_gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      gap = int'($urandom_range(gmax, gmin));
      for (int g = 0; g < gap; g++) begin
        mem_rvalid = 1'b0; mem_rdata = $urandom();
        #2;
        chk("gap_we", 128'(cache_we), 128'(0));
        chk("gap_req", 128'(mem_req), 128'(0));
        tick(); cyc++;
      end
      mem_rvalid = 1'b1; mem_rdata = beats[k];
      #2;
      chk("beat_we", 128'(cache_we), 128'(0));
      tick(); cyc++;
      mem_rvalid = 1'b0; mem_rdata = $urandom();
      if (k == flush_after) begin
        flush = 1'b1;
        #2;
        chk("flush_we", 128'(cache_we), 128'(0));
        tick(); cyc++;
        flush = 1'b0;
        squashed = 1'b1;
      end
    end
    lcyc = cyc - 1;
    if (!squashed) begin
      flush = flush_wr;
      #2;
      chk("we", 128'(cache_we), 128'(1));
      chk("waddr", 128'(cache_waddr), 128'(la));
      chk("wdata", cache_wdata, line);
      chk("we_stall", 128'(stall), 128'(1));
      tick(); cyc++;
    end else begin
      cache_hit = 1'b1;
      #2;
      chk("squash_we", 128'(cache_we), 128'(0));
      tick(); cyc++;
    end
    cache_hit = 1'b1; flush = 1'b0;
    #2;
    for (int i = 0; i < 4 && stall !== 1'b0; i++) begin
      tick(); cyc++; #2;
    end
    chk("stall_drop", 128'(stall), 128'(0));
    chk("penalty", 128'(cyc), 128'(lcyc + 2));
    chk("post_we", 128'(cache_we), 128'(0));
`ifndef ICACHE_PREFETCH_EN
    chk("post_req", 128'(mem_req), 128'(0));
`endif
    penalty = cyc;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pc = 32'h104; cache_hit = 1'b0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #7;
    chk("rst_req", 128'(mem_req), 128'(0));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_we", 128'(cache_we), 128'(0));
    chk("rst_waddr", 128'(cache_waddr), 128'(0));
    chk("rst_wdata", cache_wdata, 128'(0));
    chk("rst_stall_miss", 128'(stall), 128'(1));
    cache_hit = 1'b1;
    #1;
    chk("rst_stall_hit", 128'(stall), 128'(0));
    cache_hit = 1'b0;
    tick();
    rst = 1'b0;

    refill(32'h104, 0, 0, 0, -1, 1'b0, 1'b1, pen);
    chk("min_penalty", 128'(pen), 128'(7));

`ifdef ICACHE_PREFETCH_EN
    begin
      logic [31:0]  pfb [4];
      logic [127:0] pline;
      bit           found;
      pline = '0;
      for (int k = 0; k < 4; k++) begin
        pfb[k] = $urandom();
        pline  = {pline[95:0], pfb[k]};
      end
      mem_gnt = 1'b1;
      #2;
      chk("pf_req", 128'(mem_req), 128'(1));
      chk("pf_addr", 128'(mem_addr), 128'(32'h110));
      tick();
      mem_gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mem_rvalid = 1'b1; mem_rdata = pfb[k];
        tick();
      end
      mem_rvalid = 1'b0;
      tick();
      pc = 32'h118; cache_hit = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
        #2;
        chk("pf_noreq", 128'(mem_req), 128'(0));
        if (cache_we === 1'b1) begin
          chk("pf_waddr", 128'(cache_waddr), 128'(32'h110));
          chk("pf_wdata", cache_wdata, pline);
          found = 1'b1;
          break;
        end
        tick();
      end
      chk("pf_we_seen", 128'(found), 128'(1));
    end
`else
    refill(32'h2C8, 5, 1, 1, -1, 1'b0, 1'b0, pen);
    refill(32'h1F4, 1, 0, 0, 1, 1'b0, 1'b0, pen);
    refill(32'h20C, 0, 0, 1, -1, 1'b0, 1'b0, pen);
    refill($urandom(), 2, 0, 2, -1, 1'b1, 1'b0, pen);

    // Flush while the request is still waiting for its grant.
    pc = 32'h480; cache_hit = 1'b0;
    #2;
    tick();
    flush = 1'b1;
    #2;
    chk("freq_req", 128'(mem_req), 128'(1));
    tick();
    flush = 1'b0; cache_hit = 1'b1;
    #2;
    chk("freq_dropped", 128'(mem_req), 128'(0));
    chk("freq_stall", 128'(stall), 128'(0));
    tick();

    // Reset in the middle of a fill, followed by stray beats.
    pc = 32'h3A4; cache_hit = 1'b0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1;
    tick();
    mem_rdata = 32'h2;
    tick();
    mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_req", 128'(mem_req), 128'(0));
    chk("mrst_addr", 128'(mem_addr), 128'(0));
    chk("mrst_we", 128'(cache_we), 128'(0));
    chk("mrst_waddr", 128'(cache_waddr), 128'(0));
    chk("mrst_wdata", cache_wdata, 128'(0));
    chk("mrst_stall", 128'(stall), 128'(1));
    cache_hit = 1'b1;
    #1;
    chk("mrst_stall_hit", 128'(stall), 128'(0));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom();
      #2;
      chk("stray_we", 128'(cache_we), 128'(0));
      chk("stray_req", 128'(mem_req), 128'(0));
      tick();
    end
    mem_rvalid = 1'b0;
    tick();
    refill(32'h3A4, 0, 0, 0, -1, 1'b0, 1'b0, pen);

    for (int n = 0; n < 12; n++) begin
      int fa;
      fa = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 0)) : -1;
      refill($urandom(), int'($urandom_range(4, 0)), 0, int'($urandom_range(2, 0)),
             fa, 1'($urandom_range(1, 0)), 1'b0, pen);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
